// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register feeding the 16-bit alu, with flush/hold/load-use bubbles.
// Build macro FORWARDING_EN enables the EX/MEM > MEM/WB bypass; without it every RAW hazard stalls.
module id_ex_stage #(
    parameter int WORD   = 16,
    parameter int REGIDX = 2
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              id_valid,
    input  logic [REGIDX-1:0] id_rs,
    input  logic [REGIDX-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [WORD-1:0]   id_rs_data,
    input  logic [WORD-1:0]   id_rt_data,
    input  logic [WORD-1:0]   id_imm,
    input  logic              id_alu_src,
    input  logic [2:0]        id_func_code,
    input  logic [1:0]        id_branch_type,
    input  logic              id_is_branch,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_reg_write,
    input  logic [REGIDX-1:0] id_dest,

    input  logic              flush,
    input  logic              hold,

    input  logic              exm_reg_write,
    input  logic              wb_reg_write,
    input  logic [REGIDX-1:0] exm_dest,
    input  logic [REGIDX-1:0] wb_dest,
    input  logic [WORD-1:0]   exm_value,
    input  logic [WORD-1:0]   wb_value,

    output logic              stall_req,
    output logic [WORD-1:0]   alu_a,
    output logic [WORD-1:0]   alu_b,
    output logic [2:0]        alu_func_code,
    output logic [1:0]        alu_branch_type,
    output logic              ex_valid,
    output logic              ex_is_branch,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_reg_write,
    output logic [REGIDX-1:0] ex_dest,
    output logic [WORD-1:0]   ex_store_data
);

    localparam logic [2:0] FUNC_ADD  = 3'b000;
    localparam logic [1:0] BRANCH_NE = 2'b00;

    typedef struct packed {
        logic              valid;
        logic              is_branch;
        logic              mem_read;
        logic              mem_write;
        logic              reg_write;
        logic              use_rs;
        logic              use_rt;
        logic              alu_src;
        logic [REGIDX-1:0] rs;
        logic [REGIDX-1:0] rt;
        logic [REGIDX-1:0] dest;
        logic [2:0]        func_code;
        logic [1:0]        branch_type;
        logic [WORD-1:0]   rs_data;
        logic [WORD-1:0]   rt_data;
        logic [WORD-1:0]   imm;
    } ex_state_t;

    ex_state_t       state_q;
    ex_state_t       state_d;
    logic            load_use;
    logic [WORD-1:0] fwd_rs;
    logic [WORD-1:0] fwd_rt;

    // A bubble keeps its data but reads as a harmless ADD with no side effects.
    function automatic ex_state_t make_bubble(input ex_state_t s);
        ex_state_t b;
        b             = s;
        b.valid       = 1'b0;
        b.is_branch   = 1'b0;
        b.mem_read    = 1'b0;
        b.mem_write   = 1'b0;
        b.reg_write   = 1'b0;
        b.use_rs      = 1'b0;
        b.use_rt      = 1'b0;
        b.func_code   = FUNC_ADD;
        b.branch_type = BRANCH_NE;
        return b;
    endfunction

    always_comb begin
        load_use = id_valid && state_q.valid && state_q.mem_read &&
                   ((id_use_rs && (id_rs == state_q.dest)) ||
                    (id_use_rt && (id_rt == state_q.dest)));
    end

`ifdef FORWARDING_EN
    always_comb begin
        fwd_rs = state_q.rs_data;
        if (state_q.use_rs && exm_reg_write && (exm_dest == state_q.rs)) begin
            fwd_rs = exm_value;
        end else if (state_q.use_rs && wb_reg_write && (wb_dest == state_q.rs)) begin
            fwd_rs = wb_value;
        end

        fwd_rt = state_q.rt_data;
        if (state_q.use_rt && exm_reg_write && (exm_dest == state_q.rt)) begin
            fwd_rt = exm_value;
        end else if (state_q.use_rt && wb_reg_write && (wb_dest == state_q.rt)) begin
            fwd_rt = wb_value;
        end

        stall_req = load_use;
    end
`else
    logic rs_pending;
    logic rt_pending;
    logic unused_fwd_inputs;

    // Results still in EX or EX/MEM are not yet in the register file; WB is covered by write-before-read.
    always_comb begin
        rs_pending = (state_q.valid && state_q.reg_write && (state_q.dest == id_rs)) ||
                     (exm_reg_write && (exm_dest == id_rs));
        rt_pending = (state_q.valid && state_q.reg_write && (state_q.dest == id_rt)) ||
                     (exm_reg_write && (exm_dest == id_rt));
        fwd_rs     = state_q.rs_data;
        fwd_rt     = state_q.rt_data;
        stall_req  = load_use ||
                     (id_valid && ((id_use_rs && rs_pending) || (id_use_rt && rt_pending)));
        unused_fwd_inputs = ^{exm_value, state_q.use_rs, state_q.use_rt};
    end
`endif

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = make_bubble(state_q);
        end else if (hold) begin
            // A writeback retiring while frozen would otherwise be lost to this instruction.
            if (wb_reg_write && (wb_dest == state_q.rs)) begin
                state_d.rs_data = wb_value;
            end
            if (wb_reg_write && (wb_dest == state_q.rt)) begin
                state_d.rt_data = wb_value;
            end
        end else if (stall_req) begin
            state_d = make_bubble(state_q);
        end else begin
            state_d.valid       = id_valid;
            state_d.is_branch   = id_valid && id_is_branch;
            state_d.mem_read    = id_valid && id_mem_read;
            state_d.mem_write   = id_valid && id_mem_write;
            state_d.reg_write   = id_valid && id_reg_write;
            state_d.use_rs      = id_valid && id_use_rs;
            state_d.use_rt      = id_valid && id_use_rt;
            state_d.alu_src     = id_alu_src;
            state_d.rs          = id_rs;
            state_d.rt          = id_rt;
            state_d.dest        = id_dest;
            state_d.func_code   = id_valid ? id_func_code : FUNC_ADD;
            state_d.branch_type = id_valid ? id_branch_type : BRANCH_NE;
            state_d.rs_data     = id_rs_data;
            state_d.rt_data     = id_rt_data;
            state_d.imm         = id_imm;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= make_bubble(ex_state_t'('0));
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        alu_a           = fwd_rs;
        alu_b           = state_q.alu_src ? state_q.imm : fwd_rt;
        ex_store_data   = fwd_rt;
        alu_func_code   = state_q.func_code;
        alu_branch_type = state_q.branch_type;
        ex_valid        = state_q.valid;
        ex_is_branch    = state_q.is_branch;
        ex_mem_read     = state_q.mem_read;
        ex_mem_write    = state_q.mem_write;
        ex_reg_write    = state_q.reg_write;
        ex_dest         = state_q.dest;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and random checks of id_ex_stage against an instruction-level model of EX.
// Honours FORWARDING_EN the same way the design does.
module tb_id_ex_stage;

    localparam int WORD   = 16;
    localparam int REGIDX = 2;
    localparam logic [2:0] FUNC_ADD  = 3'b000;
    localparam logic [1:0] BRANCH_NE = 2'b00;
`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n;
    logic              id_valid, id_use_rs, id_use_rt, id_alu_src;
    logic [REGIDX-1:0] id_rs, id_rt, id_dest;
    logic [WORD-1:0]   id_rs_data, id_rt_data, id_imm;
    logic [2:0]        id_func_code;
    logic [1:0]        id_branch_type;
    logic              id_is_branch, id_mem_read, id_mem_write, id_reg_write;
    logic              flush, hold;
    logic              exm_reg_write, wb_reg_write;
    logic [REGIDX-1:0] exm_dest, wb_dest;
    logic [WORD-1:0]   exm_value, wb_value;
    logic              stall_req;
    logic [WORD-1:0]   alu_a, alu_b, ex_store_data;
    logic [2:0]        alu_func_code;
    logic [1:0]        alu_branch_type;
    logic              ex_valid, ex_is_branch, ex_mem_read, ex_mem_write, ex_reg_write;
    logic [REGIDX-1:0] ex_dest;

    id_ex_stage #(.WORD(WORD), .REGIDX(REGIDX)) dut (
        .clk(clk), .reset_n(reset_n),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_alu_src(id_alu_src), .id_func_code(id_func_code), .id_branch_type(id_branch_type),
        .id_is_branch(id_is_branch), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_reg_write(id_reg_write), .id_dest(id_dest),
        .flush(flush), .hold(hold),
        .exm_reg_write(exm_reg_write), .wb_reg_write(wb_reg_write),
        .exm_dest(exm_dest), .wb_dest(wb_dest), .exm_value(exm_value), .wb_value(wb_value),
        .stall_req(stall_req), .alu_a(alu_a), .alu_b(alu_b),
        .alu_func_code(alu_func_code), .alu_branch_type(alu_branch_type),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
        .ex_dest(ex_dest), .ex_store_data(ex_store_data)
    );

    always #5 clk = ~clk;

    // The instruction the bench believes occupies EX, as decoded (valid=0 means nothing there).
    typedef struct {
        logic              valid, is_branch, mem_read, mem_write, reg_write;
        logic              use_rs, use_rt, alu_src;
        logic [REGIDX-1:0] rs, rt, dest;
        logic [2:0]        func;
        logic [1:0]        br;
        logic [WORD-1:0]   rs_data, rt_data, imm;
    } instr_t;

    instr_t ex;
    int     checks = 0;
    int     errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        ex = '{default: '0};
    endtask

    // Value of a register as EX should see it: youngest in-flight result first.
    function automatic logic [WORD-1:0] ex_operand(input logic [REGIDX-1:0] r, input logic used,
                                                   input logic [WORD-1:0] captured);
`ifdef FORWARDING_EN
        if (used && exm_reg_write && exm_dest == r) return exm_value;
        if (used && wb_reg_write && wb_dest == r) return wb_value;
`endif
        return captured;
    endfunction

    function automatic bit writer_ahead(input logic [REGIDX-1:0] r);
        return (ex.valid && ex.reg_write && ex.dest == r) || (exm_reg_write && exm_dest == r);
    endfunction

    function automatic bit expect_stall();
        bit lu;
        if (!id_valid) return 1'b0;
        lu = ex.valid && ex.mem_read &&
             ((id_use_rs && id_rs == ex.dest) || (id_use_rt && id_rt == ex.dest));
        if (FWD) return lu;
        return lu || (id_use_rs && writer_ahead(id_rs)) || (id_use_rt && writer_ahead(id_rt));
    endfunction

    task automatic check_model();
        logic [WORD-1:0] b;
        chk("stall_req", stall_req, expect_stall());
        chk("ex_valid", ex_valid, ex.valid);
        chk("ex_is_branch", ex_is_branch, ex.valid && ex.is_branch);
        chk("ex_mem_read", ex_mem_read, ex.valid && ex.mem_read);
        chk("ex_mem_write", ex_mem_write, ex.valid && ex.mem_write);
        chk("ex_reg_write", ex_reg_write, ex.valid && ex.reg_write);
        chk("alu_func_code", alu_func_code, ex.valid ? ex.func : FUNC_ADD);
        chk("alu_branch_type", alu_branch_type, ex.valid ? ex.br : BRANCH_NE);
        if (ex.valid) begin
            b = ex_operand(ex.rt, ex.use_rt, ex.rt_data);
            chk("alu_a", alu_a, ex_operand(ex.rs, ex.use_rs, ex.rs_data));
            chk("alu_b", alu_b, ex.alu_src ? ex.imm : b);
            chk("ex_store_data", ex_store_data, b);
            chk("ex_dest", ex_dest, ex.dest);
        end
    endtask

    task automatic model_edge(input bit stall);
        if (!reset_n) begin
            model_reset();
        end else if (flush) begin
            ex.valid = 1'b0;
        end else if (hold) begin
            if (wb_reg_write && wb_dest == ex.rs) ex.rs_data = wb_value;
            if (wb_reg_write && wb_dest == ex.rt) ex.rt_data = wb_value;
        end else if (stall) begin
            ex.valid = 1'b0;
        end else begin
            ex = '{valid: id_valid, is_branch: id_is_branch, mem_read: id_mem_read,
                   mem_write: id_mem_write, reg_write: id_reg_write, use_rs: id_use_rs,
                   use_rt: id_use_rt, alu_src: id_alu_src, rs: id_rs, rt: id_rt, dest: id_dest,
                   func: id_func_code, br: id_branch_type, rs_data: id_rs_data,
                   rt_data: id_rt_data, imm: id_imm};
        end
    endtask

    task automatic tick();
        bit s;
        #1;
        check_model();
        s = expect_stall();
        @(posedge clk);
        model_edge(s);
        @(negedge clk);
    endtask

    task automatic drive_idle();
        {id_valid, id_use_rs, id_use_rt, id_alu_src, id_is_branch} = '0;
        {id_mem_read, id_mem_write, id_reg_write, flush, hold} = '0;
        {id_rs, id_rt, id_dest, exm_dest, wb_dest} = '0;
        {id_rs_data, id_rt_data, id_imm, exm_value, wb_value} = '0;
        id_func_code = FUNC_ADD;
        id_branch_type = BRANCH_NE;
        exm_reg_write = 1'b0;
        wb_reg_write = 1'b0;
    endtask

    task automatic drive_random();
        {id_valid, id_use_rs, id_use_rt, id_alu_src, id_is_branch} = 5'($urandom);
        {id_mem_read, id_mem_write, id_reg_write} = 3'($urandom);
        {id_rs, id_rt, id_dest, exm_dest, wb_dest} = 10'($urandom);
        id_rs_data = 16'($urandom);
        id_rt_data = 16'($urandom);
        id_imm = 16'($urandom);
        exm_value = 16'($urandom);
        wb_value = 16'($urandom);
        id_func_code = 3'($urandom);
        id_branch_type = 2'($urandom);
        exm_reg_write = 1'($urandom);
        wb_reg_write = 1'($urandom);
        flush = ($urandom_range(0, 7) == 0);
        hold = ($urandom_range(0, 5) == 0);
    endtask

    initial begin
        drive_idle();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ex_valid", ex_valid, 1'b0);
        chk("rst_alu_a", alu_a, 16'h0000);
        chk("rst_alu_b", alu_b, 16'h0000);
        chk("rst_store", ex_store_data, 16'h0000);
        chk("rst_func", alu_func_code, FUNC_ADD);
        chk("rst_branch", alu_branch_type, BRANCH_NE);
        chk("rst_dest", ex_dest, 2'd0);
        chk("rst_stall", stall_req, 1'b0);
        reset_n = 1'b1;
        tick();

        // ADD r1, r2, r3
        id_valid = 1; id_rs = 2; id_rt = 3; id_use_rs = 1; id_use_rt = 1;
        id_rs_data = 16'h0005; id_rt_data = 16'h0003; id_reg_write = 1; id_dest = 1;
        tick();
        drive_idle();
        #1;
        chk("add_alu_a", alu_a, 16'h0005);
        chk("add_alu_b", alu_b, 16'h0003);
        chk("add_reg_write", ex_reg_write, 1'b1);
        chk("add_dest", ex_dest, 2'd1);
        tick();

        // Both downstream stages write the register EX reads
        id_valid = 1; id_rs = 2; id_use_rs = 1; id_rs_data = 16'h00AA;
        tick();
        drive_idle();
        exm_reg_write = 1; exm_dest = 2; exm_value = 16'h1111;
        wb_reg_write = 1; wb_dest = 2; wb_value = 16'h2222;
        #1 chk("fwd_both", alu_a, FWD ? 16'h1111 : 16'h00AA);
        exm_reg_write = 0;
        #1 chk("fwd_wb_only", alu_a, FWD ? 16'h2222 : 16'h00AA);
        tick();

        // Load-use: LWD r1 in EX, dependent ADD in ID
        drive_idle();
        id_valid = 1; id_use_rs = 1; id_mem_read = 1; id_reg_write = 1; id_dest = 1;
        tick();
        drive_idle();
        id_valid = 1; id_rs = 1; id_use_rs = 1; id_rt = 2; id_use_rt = 1;
        id_rs_data = 16'hDEAD; id_rt_data = 16'h0007; id_reg_write = 1; id_dest = 3;
        #1 chk("lu_stall", stall_req, 1'b1);
        tick();
        #1 chk("lu_bubble", ex_valid, 1'b0);
        exm_reg_write = 1; exm_dest = 1; exm_value = 16'h4321;
        #1 chk("lu_stall_next", stall_req, !FWD);
        tick();
        if (!FWD) begin
            exm_reg_write = 0; wb_reg_write = 1; wb_dest = 1; wb_value = 16'h4321;
            id_rs_data = 16'h4321;
            #1 chk("lu_stall_clear", stall_req, 1'b0);
            tick();
            wb_reg_write = 0;
        end else begin
            exm_reg_write = 0; wb_reg_write = 1; wb_dest = 1; wb_value = 16'h4321;
        end
        id_valid = 0;
        #1;
        chk("lu_add_valid", ex_valid, 1'b1);
        chk("lu_alu_a", alu_a, 16'h4321);
        tick();

        // Hold with a retiring writeback to the stored rt
        drive_idle();
        id_valid = 1; id_rt = 3; id_use_rt = 1; id_rt_data = 16'h0000;
        tick();
        drive_idle();
        hold = 1; wb_reg_write = 1; wb_dest = 3; wb_value = 16'hBEEF;
        tick();
        wb_reg_write = 0;
        tick();
        hold = 0;
        #1;
        chk("hold_valid", ex_valid, 1'b1);
        chk("hold_alu_b", alu_b, 16'hBEEF);
        tick();

        // Flush and hold on the same edge
        drive_idle();
        id_valid = 1; id_mem_write = 1; id_rs = 2; id_use_rs = 1;
        tick();
        drive_idle();
        flush = 1; hold = 1;
        tick();
        flush = 0; hold = 0;
        #1;
        chk("flush_valid", ex_valid, 1'b0);
        chk("flush_mem_write", ex_mem_write, 1'b0);
        id_valid = 1; id_use_rs = 1; id_rs = 2; exm_reg_write = 1; exm_dest = 2;
        #1 chk("raw_exm_stall", stall_req, !FWD);
        tick();

        for (int n = 0; n < 300; n++) begin
            drive_random();
            tick();
        end

        // Asynchronous reset arriving mid-hold
        drive_random();
        hold = 1;
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_valid", ex_valid, 1'b0);
        chk("mid_rst_reg_write", ex_reg_write, 1'b0);
        chk("mid_rst_alu_a", alu_a, 16'h0000);
        chk("mid_rst_alu_b", alu_b, 16'h0000);
        chk("mid_rst_store", ex_store_data, 16'h0000);
        chk("mid_rst_func", alu_func_code, FUNC_ADD);
        chk("mid_rst_dest", ex_dest, 2'd0);
        tick();
        reset_n = 1'b1;

        for (int n = 0; n < 100; n++) begin
            drive_random();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
